// File: rtl/perf_counter_unit_pkg.sv
// Shared types and constants for the performance-counter unit.
package perf_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } perfState_t;

  localparam int CH_CYCLE     = 0;   // channel index of the free-running cycle counter
  localparam int MAX_CHANNELS = 17;  // cycle channel plus up to 16 event channels
endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: synchronous clear, gated increment, wrap or saturate on overflow.
module perf_counter_cell #(
  parameter int CNT_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 ovfPulse
);
  logic atMax;

  assign atMax    = &value;
  // clear wins over increment, so a cleared cycle can never report an overflow
  assign ovfPulse = inc & ~clr & atMax;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      if (atMax) begin
        value <= (SATURATE != 0) ? value : '0;
      end else begin
        value <= value + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle + event counters under a start/stop FSM,
// sticky overflow flags, an atomic shadow snapshot and a registered read port.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS  = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int SATURATE    = 0,
  parameter int STOP_ON_OVF = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              clear,
  input  logic [NUM_EVENTS-1:0]             event_i,
  input  logic                              snap,
  output logic                              snap_valid,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]   rd_sel,
  output logic [CNT_WIDTH-1:0]              rd_data,
  output logic [NUM_EVENTS:0]               ovf,
  output logic                              running,
  output logic                              irq
);
  localparam int NUM_CH = NUM_EVENTS + 1;
  localparam int SEL_W  = $clog2(NUM_EVENTS + 1);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_EVENTS);

  perfState_t           stateReg;
  logic                 runningReg;
  logic                 snapValidReg;
  logic                 irqReg;
  logic                 isRun;
  logic [NUM_CH-1:0]    incVec;
  logic [NUM_CH-1:0]    ovfPulse;
  logic [NUM_CH-1:0]    ovfReg;
  logic [CNT_WIDTH-1:0] countVal  [NUM_CH];
  logic [CNT_WIDTH-1:0] shadowReg [NUM_CH];
  logic [CNT_WIDTH-1:0] rdDataReg;

  assign isRun = (stateReg == RUN);

  always_comb begin
    incVec           = '0;
    incVec[CH_CYCLE] = isRun;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      incVec[k+1] = isRun & event_i[k];
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gChannel
    perf_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH),
      .SATURATE (SATURATE)
    ) uCell (
      .clk     (clk),
      .rst     (rst),
      .inc     (incVec[gi]),
      .clr     (clear),
      .value   (countVal[gi]),
      .ovfPulse(ovfPulse[gi])
    );

    // shadows sample the pre-update counter values, so snap+clear keeps the old counts
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadowReg[gi] <= '0;
      end else if (snap) begin
        shadowReg[gi] <= countVal[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg   <= IDLE;
      runningReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start && !stop) begin
            stateReg   <= RUN;
            runningReg <= 1'b1;
          end
        end
        RUN: begin
          // an overflow halt takes precedence over a simultaneous stop
          if ((STOP_ON_OVF != 0) && (|ovfPulse)) begin
            stateReg   <= HALTED;
            runningReg <= 1'b0;
          end else if (stop) begin
            stateReg   <= IDLE;
            runningReg <= 1'b0;
          end
        end
        HALTED: begin
          if (clear) begin
            stateReg   <= IDLE;
            runningReg <= 1'b0;
          end
        end
        default: begin
          stateReg   <= IDLE;
          runningReg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovfReg       <= '0;
      irqReg       <= 1'b0;
      snapValidReg <= 1'b0;
      rdDataReg    <= '0;
    end else begin
      ovfReg       <= clear ? '0 : (ovfReg | ovfPulse);
      irqReg       <= |ovfReg;
      snapValidReg <= snap;
      rdDataReg    <= (rd_sel <= LAST_CH) ? shadowReg[rd_sel] : '0;
    end
  end

  assign snap_valid = snapValidReg;
  assign rd_data    = rdDataReg;
  assign ovf        = ovfReg;
  assign running    = runningReg;
  assign irq        = irqReg;
endmodule
